mips_multicycle_control: RTL and testbench
==========================================

MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

Interface
REQ-001 Parameter LW, 6'b100011, load-word opcode.
REQ-002 Parameter SW, 6'b101011, store-word opcode.
REQ-003 Parameter BEQ, 6'b000100, branch-equal opcode.
REQ-004 Parameter J, 6'd2, jump opcode.
REQ-005 Parameter RTYPE, 6'b000000, R-format opcode.
REQ-006 The block SHALL use one clock; reset is asynchronous and active-high, with ports named clock and reset.
REQ-007 The block SHALL have these ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  6  IR[31:26] from the datapath.
- ALUOp, ALUSrcB, PCSource  out  2 each  datapath controls.
- RegDst, MemtoReg, MemRead, MemWrite, IorD, RegWrite, IRWrite, PCWrite, PCWriteCond, ALUSrcA  out  1 each  datapath controls.
- state  out  4  current FSM state code.
- illegal_op  out  1  sticky unsupported-opcode flag.
- instr_count  out  32  retired-instruction counter.

Function
REQ-008 The block SHALL be a Moore FSM: all control outputs decode from the state register only, never from opcode.
REQ-009 State codes SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RCOMP=7, BRANCH=8, JUMP=9. Codes 10-15 are unused.
REQ-010 Outputs not listed for a state SHALL be 0 in that state.
- FETCH: MemRead=1, IRWrite=1, ALUSrcB=01, PCWrite=1.
- DECODE: ALUSrcB=11.
- MEMADR: ALUSrcA=1, ALUSrcB=10.
- MEMRD: MemRead=1, IorD=1.
- MEMWB: RegWrite=1, MemtoReg=1.
- MEMWR: MemWrite=1, IorD=1.
- EXEC: ALUSrcA=1, ALUOp=10.
- RCOMP: RegDst=1, RegWrite=1.
- BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01.
- JUMP: PCWrite=1, PCSource=10.
REQ-011 Transitions SHALL occur on the rising edge of clock:
- FETCH -> DECODE.
- DECODE -> MEMADR for LW or SW; EXEC for RTYPE; BRANCH for BEQ; JUMP for J; FETCH for any other opcode.
- MEMADR -> MEMRD for LW; MEMWR otherwise.
- MEMRD -> MEMWB.
- EXEC -> RCOMP.
- MEMWB, MEMWR, RCOMP, BRANCH and JUMP -> FETCH.
- Unused codes -> FETCH.
REQ-012 opcode SHALL be sampled in DECODE and MEMADR only; in other states it SHALL be don't-care.
REQ-013 Cycles per instruction, FETCH entry to next FETCH entry, SHALL be: LW 5, SW 4, RTYPE 4, BEQ 3, J 3, illegal 2.
REQ-014 An unsupported opcode in DECODE SHALL set illegal_op=1 on that edge. It stays 1 until reset. The FSM continues fetching.
REQ-015 instr_count SHALL increment by 1 on each edge leaving MEMWB, MEMWR, RCOMP, BRANCH or JUMP. Illegal instructions SHALL NOT be counted.
REQ-016 instr_count SHALL wrap from 32'hFFFFFFFF to 0 without a flag.
REQ-017 MemRead and MemWrite SHALL never both be 1. RegWrite and MemWrite SHALL never both be 1.

Reset
REQ-018 While reset=1, the block SHALL immediately force state=FETCH, illegal_op=0, instr_count=0 and all control outputs to 0, independent of clock.
REQ-019 After reset deasserts, FETCH outputs SHALL appear. The first rising edge performs the first fetch.
REQ-020 Reset asserted mid-instruction, in any state, SHALL abort the instruction. The aborted instruction SHALL NOT be counted.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset, then opcode=100011 -> states 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 only in state 4. instr_count=1 after 5 edges.
- opcode=101011 -> states 0,1,2,5,0. MemWrite=1 and IorD=1 in state 5 only. instr_count=1.
- opcode=000000 -> states 0,1,6,7,0. ALUOp=10 in 6; RegDst=1 and RegWrite=1 in 7.
- opcode=000100, then opcode=000010 -> states 0,1,8,0,1,9,0. PCWriteCond=1 in 8; PCSource=10 and PCWrite=1 in 9. instr_count=2.
- opcode=111111 -> states 0,1,0. illegal_op=1 from the DECODE edge onward. instr_count unchanged.
- Reset asserted asynchronously in MEMRD -> state=0, all outputs 0 and instr_count=0 before the next edge.

Source files
------------

// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multicycle MIPS datapath and its main control FSM.
// The datapath (master) supplies the opcode field; the control (slave) drives everything else.
interface mips_multicycle_control_if;
    logic [5:0]  opcode;
    logic [1:0]  ALUOp;
    logic [1:0]  ALUSrcB;
    logic [1:0]  PCSource;
    logic        RegDst;
    logic        MemtoReg;
    logic        MemRead;
    logic        MemWrite;
    logic        IorD;
    logic        RegWrite;
    logic        IRWrite;
    logic        PCWrite;
    logic        PCWriteCond;
    logic        ALUSrcA;
    logic [3:0]  state;
    logic        illegal_op;
    logic [31:0] instr_count;

    modport master (
        output opcode,
        input  ALUOp, ALUSrcB, PCSource, RegDst, MemtoReg, MemRead, MemWrite,
        input  IorD, RegWrite, IRWrite, PCWrite, PCWriteCond, ALUSrcA,
        input  state, illegal_op, instr_count
    );

    modport slave (
        input  opcode,
        output ALUOp, ALUSrcB, PCSource, RegDst, MemtoReg, MemRead, MemWrite,
        output IorD, RegWrite, IRWrite, PCWrite, PCWriteCond, ALUSrcA,
        output state, illegal_op, instr_count
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control: a Moore FSM sequencing fetch/decode/execute phases,
// plus a sticky illegal-opcode flag and a retired-instruction counter.
module mips_multicycle_control #(
    parameter logic [5:0] LW    = 6'b100011,
    parameter logic [5:0] SW    = 6'b101011,
    parameter logic [5:0] BEQ   = 6'b000100,
    parameter logic [5:0] J     = 6'd2,
    parameter logic [5:0] RTYPE = 6'b000000
) (
    input  logic clock,
    input  logic reset,
    mips_multicycle_control_if.slave ctl
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RCOMP  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
    } state_e;

    state_e      state_q, state_d;
    logic        illegal_q, illegal_d;
    logic [31:0] count_q, count_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            count_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    // The opcode is only consulted in DECODE and MEMADR; the IR may hold anything elsewhere.
    always_comb begin
        state_d   = S_FETCH;
        illegal_d = illegal_q;
        count_d   = count_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (ctl.opcode)
                    LW, SW:  state_d = S_MEMADR;
                    RTYPE:   state_d = S_EXEC;
                    BEQ:     state_d = S_BRANCH;
                    J:       state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (ctl.opcode == LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_RCOMP;
            S_MEMWB, S_MEMWR, S_RCOMP, S_BRANCH, S_JUMP: begin
                // Retirement edge; the counter wraps naturally at 2^32.
                state_d = S_FETCH;
                count_d = count_q + 32'd1;
            end
            default:  state_d = S_FETCH;
        endcase
    end

    logic [1:0] alu_op, alu_src_b, pc_source;
    logic       reg_dst, mem_to_reg, mem_read, mem_write, i_or_d;
    logic       reg_write, ir_write, pc_write, pc_write_cond, alu_src_a;

    // Controls depend on the state register only; reset blanks them even though the state reads FETCH.
    always_comb begin
        alu_op        = 2'b00;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        reg_write     = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        alu_src_a     = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    ir_write  = 1'b1;
                    alu_src_b = 2'b01;
                    pc_write  = 1'b1;
                end
                S_DECODE: alu_src_b = 2'b11;
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_RCOMP: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
                default: ;
            endcase
        end
    end

    assign ctl.ALUOp       = alu_op;
    assign ctl.ALUSrcB     = alu_src_b;
    assign ctl.PCSource    = pc_source;
    assign ctl.RegDst      = reg_dst;
    assign ctl.MemtoReg    = mem_to_reg;
    assign ctl.MemRead     = mem_read;
    assign ctl.MemWrite    = mem_write;
    assign ctl.IorD        = i_or_d;
    assign ctl.RegWrite    = reg_write;
    assign ctl.IRWrite     = ir_write;
    assign ctl.PCWrite     = pc_write;
    assign ctl.PCWriteCond = pc_write_cond;
    assign ctl.ALUSrcA     = alu_src_a;
    assign ctl.state       = state_q;
    assign ctl.illegal_op  = illegal_q;
    assign ctl.instr_count = count_q;

    // Memory port and register file must never be driven into conflicting operations.
    a_no_rd_wr: assert property (@(posedge clock) disable iff (reset) !(mem_read && mem_write));
    a_no_rw_mw: assert property (@(posedge clock) disable iff (reset) !(reg_write && mem_write));

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Randomized instruction-stream bench for the multicycle control FSM, checked every cycle
// against an instruction-level model (per-opcode state paths, retire count, illegal flag).
module tb_mips_multicycle_control;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J = 6'd2;
  localparam logic [5:0] OP_R = 6'b000000;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mips_multicycle_control_if bus();
  mips_multicycle_control dut (.clock(clock), .reset(reset), .ctl(bus));

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] dut_ctrl();
    return {bus.ALUOp, bus.ALUSrcB, bus.PCSource, bus.RegDst, bus.MemtoReg, bus.MemRead,
            bus.MemWrite, bus.IorD, bus.RegWrite, bus.IRWrite, bus.PCWrite, bus.PCWriteCond,
            bus.ALUSrcA};
  endfunction

  // ---------------- behavioural model ----------------
  // Control table written straight from the per-state output list.
  function automatic logic [15:0] exp_ctrl(input int s);
    logic [1:0] aluop = 2'b00, srcb = 2'b00, pcsrc = 2'b00;
    logic regdst = 0, m2r = 0, mrd = 0, mwr = 0, iord = 0, rw = 0, irw = 0, pcw = 0, pcwc = 0, srca = 0;
    case (s)
      0: begin mrd = 1; irw = 1; srcb = 2'b01; pcw = 1; end
      1: srcb = 2'b11;
      2: begin srca = 1; srcb = 2'b10; end
      3: begin mrd = 1; iord = 1; end
      4: begin rw = 1; m2r = 1; end
      5: begin mwr = 1; iord = 1; end
      6: begin srca = 1; aluop = 2'b10; end
      7: begin regdst = 1; rw = 1; end
      8: begin srca = 1; aluop = 2'b01; pcwc = 1; pcsrc = 2'b01; end
      9: begin pcw = 1; pcsrc = 2'b10; end
      default: ;
    endcase
    return {aluop, srcb, pcsrc, regdst, m2r, mrd, mwr, iord, rw, irw, pcw, pcwc, srca};
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_J) || (op == OP_R);
  endfunction

  int          m_state;
  logic [5:0]  m_op;
  logic        m_illegal;
  logic [31:0] m_count;
  int          path_q[$];
  logic [5:0]  op_q[$];
  logic [52:0] exp_q[$];
  bit          chk_en = 0;

  function automatic logic [5:0] random_op();
    logic [5:0] op;
    case ($urandom_range(0, 5))
      0: op = OP_LW;
      1: op = OP_SW;
      2: op = OP_R;
      3: op = OP_BEQ;
      4: op = OP_J;
      default: begin
        op = 6'($urandom_range(0, 63));
        while (is_legal(op)) op = 6'($urandom_range(0, 63));
      end
    endcase
    return op;
  endfunction

  // States visited after FETCH; the path length plus one is the instruction's CPI.
  task automatic start_instr();
    m_op = (op_q.size() > 0) ? op_q.pop_front() : random_op();
    m_state = 0;
    path_q.delete();
    path_q.push_back(1);
    case (m_op)
      OP_LW:  begin path_q.push_back(2); path_q.push_back(3); path_q.push_back(4); end
      OP_SW:  begin path_q.push_back(2); path_q.push_back(5); end
      OP_R:   begin path_q.push_back(6); path_q.push_back(7); end
      OP_BEQ: path_q.push_back(8);
      OP_J:   path_q.push_back(9);
      default: ;
    endcase
  endtask

  task automatic model_reset();
    m_count = 32'd0;
    m_illegal = 1'b0;
    start_instr();
  endtask

  task automatic model_step();
    if (path_q.size() > 0) m_state = path_q.pop_front();
    else begin
      if (is_legal(m_op)) m_count = m_count + 32'd1;
      else m_illegal = 1'b1;
      start_instr();
    end
  endtask

  task automatic push_expect();
    logic [15:0] c;
    c = reset ? 16'h0 : exp_ctrl(m_state);
    exp_q.push_back({4'(m_state), m_illegal, m_count, c});
  endtask

  // ---------------- scoreboard compare ----------------
  always @(negedge clock) begin
    logic [52:0] e;
    if (chk_en) begin
      if (exp_q.size() == 0) chk("scoreboard_empty", 64'(exp_q.size()), 64'd1);
      else begin
        e = exp_q.pop_front();
        chk("state", 64'(bus.state), 64'(e[52:49]));
        chk("illegal_op", 64'(bus.illegal_op), 64'(e[48]));
        chk("instr_count", 64'(bus.instr_count), 64'(e[47:16]));
        chk("controls", 64'(dut_ctrl()), 64'(e[15:0]));
        chk("memrd_memwr_excl", 64'(bus.MemRead & bus.MemWrite), 64'd0);
        chk("regwr_memwr_excl", 64'(bus.RegWrite & bus.MemWrite), 64'd0);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic async_reset_checks(input string tag);
    chk({tag, "_state"}, 64'(bus.state), 64'd0);
    chk({tag, "_ctrl"}, 64'(dut_ctrl()), 64'd0);
    chk({tag, "_count"}, 64'(bus.instr_count), 64'd0);
    chk({tag, "_illegal"}, 64'(bus.illegal_op), 64'd0);
  endtask

  // One clock cycle; opcode carries the instruction only where it is sampled, noise elsewhere.
  task automatic cycle(input bit rst_pulse);
    @(negedge clock);
    #1;
    if (!rst_pulse) reset = 1'b0;
    bus.opcode = (m_state == 1 || m_state == 2) ? m_op : 6'($urandom_range(0, 63));
    if (rst_pulse) begin
      #2;
      reset = 1'b1;
      #1;
      async_reset_checks("async_rst");
    end
    @(posedge clock);
    #1;
    if (reset) model_reset();
    else model_step();
    push_expect();
  endtask

  int dir_states[21] = '{1, 2, 3, 4, 0, 1, 2, 5, 0, 1, 6, 7, 0, 1, 8, 0, 1, 9, 0, 1, 0};

  initial begin
    bus.opcode = 6'd0;
    #2;
    async_reset_checks("por");

    op_q.push_back(OP_LW);
    op_q.push_back(OP_SW);
    op_q.push_back(OP_R);
    op_q.push_back(OP_BEQ);
    op_q.push_back(OP_J);
    op_q.push_back(6'b111111);
    @(posedge clock);
    #1;
    model_reset();
    push_expect();
    chk_en = 1;

    // Directed program with hand-derived state trace and milestones.
    for (int i = 0; i < 21; i++) begin
      cycle(1'b0);
      chk("dir_state", 64'(bus.state), 64'(dir_states[i]));
      case (i)
        3:  chk("lw_wb_regwrite_memtoreg", 64'({bus.RegWrite, bus.MemtoReg}), 64'b11);
        4:  chk("lw_count", 64'(bus.instr_count), 64'd1);
        7:  chk("sw_memwrite_iord", 64'({bus.MemWrite, bus.IorD}), 64'b11);
        8:  chk("sw_count", 64'(bus.instr_count), 64'd2);
        10: chk("rtype_aluop", 64'(bus.ALUOp), 64'd2);
        11: chk("rtype_regdst_regwrite", 64'({bus.RegDst, bus.RegWrite}), 64'b11);
        14: chk("beq_pcwritecond", 64'(bus.PCWriteCond), 64'd1);
        17: chk("j_pcsource_pcwrite", 64'({bus.PCSource, bus.PCWrite}), 64'b101);
        18: chk("beq_j_count", 64'(bus.instr_count), 64'd5);
        19: chk("pre_illegal_flag", 64'(bus.illegal_op), 64'd0);
        20: begin
          chk("illegal_flag", 64'(bus.illegal_op), 64'd1);
          chk("illegal_not_counted", 64'(bus.instr_count), 64'd5);
        end
        default: ;
      endcase
    end

    // Abort a load in MEMRD with an asynchronous reset.
    op_q.push_back(OP_LW);
    cycle(1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0);
    chk("lw_in_memrd", 64'(bus.state), 64'd3);
    cycle(1'b1);
    cycle(1'b0);
    chk("post_abort_count", 64'(bus.instr_count), 64'd0);

    // Random instruction stream with occasional resets.
    for (int i = 0; i < 3000; i++) cycle($urandom_range(0, 299) == 0);

    @(negedge clock);
    #1;
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
